// File: rtl/systolic_result_streamer.sv
// Two-entry result buffer that streams each captured 4x4 product matrix out in row-major order.
// Latency: a result pulse sampled at edge T presents element (0,0) from cycle T+1; one beat per cycle.
// Backpressure: outputs hold while i_ready is low; a result that arrives with both buffers full is dropped and flagged.
module systolic_result_streamer #(
  parameter int DIM    = 4,
  parameter int ELEM_W = 16
) (
  input  logic                                 i_clk,
  input  logic                                 i_arst,
  input  logic [DIM-1:0][DIM-1:0][ELEM_W-1:0] i_c,
  input  logic                                 i_resultValid,
  output logic                                 o_canAccept,
  output logic                                 o_valid,
  input  logic                                 i_ready,
  output logic [ELEM_W-1:0]                    o_data,
  output logic [1:0]                           o_row,
  output logic [1:0]                           o_col,
  output logic                                 o_last,
  input  logic                                 i_clearOverflow,
  output logic                                 o_overflow
);

  // The row/column decode and the 4-bit beat index only make sense for a 4x4 array.
  if (DIM != 4) begin : g_dim_check
    $error("systolic_result_streamer: only DIM = 4 is supported");
  end

  typedef logic [DIM-1:0][DIM-1:0][ELEM_W-1:0] mat_t;

  // Buffer occupancy doubles as the control state: number of matrices held.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       wp_q, wp_d;
  logic       rp_q, rp_d;
  logic [3:0] idx_q, idx_d;
  logic       ovf_q, ovf_d;
  mat_t       buf_q [2];

  logic capture;
  logic drop;
  logic beat;
  logic final_beat;

  // Capture/drop decisions use the registered occupancy only, so a final beat
  // in the same cycle never makes room for a result arriving at FULL.
  assign capture    = i_resultValid && (state_q != ST_FULL);
  assign drop       = i_resultValid && (state_q == ST_FULL);
  assign beat       = (state_q != ST_EMPTY) && i_ready;
  assign final_beat = beat && (idx_q == 4'd15);

  // Occupancy transitions: capture fills, final beat releases, both together cancel.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (capture) state_d = ST_ONE;
      end
      ST_ONE: begin
        if (capture && !final_beat)      state_d = ST_FULL;
        else if (!capture && final_beat) state_d = ST_EMPTY;
      end
      ST_FULL: begin
        if (final_beat) state_d = ST_ONE;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Pointer, beat index and sticky overflow next-state; a drop beats a clear.
  always_comb begin
    wp_d  = wp_q ^ capture;
    rp_d  = rp_q ^ final_beat;
    idx_d = idx_q;
    if (final_beat) begin
      idx_d = 4'd0;
    end else if (beat) begin
      idx_d = idx_q + 4'd1;
    end
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (i_clearOverflow) begin
      ovf_d = 1'b0;
    end
  end

  // Control registers; reset discards any buffered or partially streamed matrix.
  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      state_q <= ST_EMPTY;
      wp_q    <= 1'b0;
      rp_q    <= 1'b0;
      idx_q   <= 4'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

  // Matrix storage; contents are only read while occupancy marks them valid, so no reset.
  always_ff @(posedge i_clk) begin
    if (capture) begin
      buf_q[wp_q] <= i_c;
    end
  end

  // Output decode purely from registers, zeroed when nothing is being presented.
  always_comb begin
    o_valid     = 1'b0;
    o_data      = '0;
    o_row       = 2'd0;
    o_col       = 2'd0;
    o_last      = 1'b0;
    o_canAccept = (state_q != ST_FULL);
    o_overflow  = ovf_q;
    if (state_q != ST_EMPTY) begin
      o_valid = 1'b1;
      o_row   = idx_q[3:2];
      o_col   = idx_q[1:0];
      o_data  = buf_q[rp_q][idx_q[3:2]][idx_q[1:0]];
      o_last  = (idx_q == 4'd15);
    end
  end

endmodule
